uart_rx_buffered: RTL and testbench
===================================

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter Data_bits, default 9, total bits per frame between start and stop, including the parity bit.
REQ-002 SHALL have parameter Os_ticks, default 16, s_ticks pulses per bit period.
REQ-003 SHALL have parameter Sync_stages, default 2, number of flops in the rx input synchronizer (minimum 2).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port s_ticks, input, 1, one-clk oversampling strobe at Os_ticks x baud.
REQ-007 SHALL have port rx, input, 1, serial line, asynchronous to clk, idle high.
REQ-008 SHALL have port rx_data, output, Data_bits-1, held payload, LSB = first received data bit.
REQ-009 SHALL have port rx_valid, output, 1, held word available.
REQ-010 SHALL have port rx_ack, input, 1, consumer pop; it clears rx_valid.
REQ-011 SHALL have port parity_err, output, 1, parity error flag for the held word.
REQ-012 SHALL have port frame_err, output, 1, stop bit sampled low for the held word.
REQ-013 SHALL have port overrun, output, 1, sticky flag: a frame was dropped because the buffer was full; cleared only by Reset.
REQ-014 SHALL have port rx_done_tick, output, 1, one-clk pulse at the end of every frame, whether accepted or dropped.

Function
REQ-015 SHALL pass rx through Sync_stages flops reset to 1; all logic SHALL use only the synchronized value rxs.
REQ-016 SHALL implement the FSM states idle, start, data, parity, stop, with a tick counter s (0..Os_ticks-1) and a bit counter n (0..Data_bits-2).
REQ-017 In idle, when rxs==0 the FSM SHALL clear s and go to start; all counting SHALL advance only on clk cycles with s_ticks=1.
REQ-018 In start, at s==Os_ticks/2-1 with s_ticks=1: if rxs==0, SHALL clear s and n and go to data; if rxs==1 (glitch), SHALL return to idle and produce no pulse or flag.
REQ-019 In data, at s==Os_ticks-1 with s_ticks=1, SHALL shift rxs into the MSB of a Data_bits-1 shift register and XOR it into a running parity; after Data_bits-1 bits SHALL go to parity.
REQ-020 In parity, SHALL sample rxs at the same tick position; parity error = (running XOR of data bits) != sampled bit (even parity).
REQ-021 In stop, SHALL sample rxs at s==Os_ticks-1; frame error = sample==0; SHALL then pulse rx_done_tick for one clk and go to idle the next cycle.
REQ-022 At frame end, if rx_valid==0 or rx_ack==1 in the same cycle, SHALL load rx_data, parity_err and frame_err and set rx_valid the next clk.
REQ-023 At frame end, if rx_valid==1 and rx_ack==0, SHALL drop the new frame, keep the held word unchanged and set overrun.
REQ-024 rx_ack with rx_valid==0 SHALL have no effect; rx_ack without a frame end SHALL clear rx_valid the next clk.
REQ-025 A new start bit SHALL be detectable in the cycle after return to idle; no extra idle time is required.
REQ-026 Counters SHALL be sized with $clog2 and SHALL never wrap within a state.

Reset
REQ-027 Reset SHALL asynchronously force: FSM=idle, s=0, n=0, shift register=0, synchronizer=1, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, rx_done_tick=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without setting any flag; after release the FSM SHALL wait for a fresh falling edge.

Verification
REQ-029 Frame 0, 8'hA5 LSB-first, parity bit 0, stop bit 1, at 16 ticks/bit -> one rx_done_tick, rx_data=8'hA5, rx_valid=1, parity_err=0, frame_err=0.
REQ-030 8'h07 with parity bit 0 (even parity requires 1) -> rx_data=8'h07, parity_err=1, frame_err=0.
REQ-031 8'h3C with stop bit 0 -> frame_err=1, rx_valid=1; the line then returns high and the next frame, 8'h55, is received cleanly after rx_ack.
REQ-032 rx low for 4 ticks then high -> no rx_done_tick, FSM back in idle, all flags 0.
REQ-033 Two frames, 8'h11 then 8'h22, with no rx_ack -> rx_data stays 8'h11, overrun=1; rx_ack in the same cycle as the frame-end of 8'h22 -> rx_data=8'h22, overrun stays 0.
REQ-034 Reset pulsed during data bit 3, then frame 8'hF0 -> rx_data=8'hF0, no error flags set.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// Purpose : oversampled UART receiver (start, Data_bits-1 data bits LSB first, even parity, stop) with a one-word hold buffer.
// Latency : rx_done_tick and the buffered word appear one clk after the mid-stop-bit sample (about 10.5 bit times after the start edge).
// Backpr. : one held word; a frame ending while the word is still held and not popped is dropped and sets sticky overrun.
//
// Ports:
//   clk, Reset    - single clock, asynchronous active-high reset
//   s_ticks       - one-clk oversampling strobe at Os_ticks x baud
//   rx            - asynchronous serial line, idle high
//   rx_data       - held payload, bit 0 = first data bit received
//   rx_valid      - held word available; rx_ack pops it
//   parity_err    - even-parity mismatch for the held word
//   frame_err     - stop bit sampled low for the held word
//   overrun       - sticky: a frame was dropped because the buffer was full
//   rx_done_tick  - one-clk pulse at the end of every frame, accepted or dropped
module uart_rx_buffered #(
    parameter int Data_bits   = 9,
    parameter int Os_ticks    = 16,
    parameter int Sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 s_ticks,
    input  logic                 rx,
    output logic [Data_bits-2:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_done_tick
);

    localparam int DW = Data_bits - 1;
    localparam int SW = (Os_ticks > 2) ? $clog2(Os_ticks) : 1;
    localparam int NW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(Os_ticks / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(Os_ticks - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DW-1:0]   shreg;
    logic            par_acc;
    logic            perr_q;
    logic [Sync_stages-1:0] sync_q;
    logic            rxs;
    logic [DW:0]     sh_next;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[Sync_stages-2:0], rx};
        end
    end

    assign rxs = sync_q[Sync_stages-1];

    // New bit enters at the MSB so the first received bit ends up in bit 0.
    assign sh_next = {rxs, shreg};

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            perr_q       <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;

            // A pop with nothing held is harmless; a frame-end load below overrides this.
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    s <= '0;
                    if (!rxs) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (s_ticks) begin
                        if (s == S_MID) begin
                            if (!rxs) begin
                                s       <= '0;
                                n       <= '0;
                                par_acc <= 1'b0;
                                state   <= ST_DATA;
                            end else begin
                                // Line went back high before mid-start: treat as noise.
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (s_ticks) begin
                        if (s == S_END) begin
                            s       <= '0;
                            shreg   <= sh_next[DW:1];
                            par_acc <= par_acc ^ rxs;
                            if (n == N_LAST) begin
                                state <= ST_PARITY;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (s_ticks) begin
                        if (s == S_END) begin
                            s      <= '0;
                            perr_q <= par_acc ^ rxs;
                            state  <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (s_ticks) begin
                        if (s == S_END) begin
                            s            <= '0;
                            state        <= ST_IDLE;
                            rx_done_tick <= 1'b1;
                            // Accept if the buffer is empty or is being popped in this very cycle.
                            if (!rx_valid || rx_ack) begin
                                rx_data    <= shreg;
                                parity_err <= perr_q;
                                frame_err  <= ~rxs;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Purpose : self-checking bench for uart_rx_buffered (directed table, corner sequences, randomized frames vs. a frame-level model).
// Latency : not applicable (bench).
// Backpr. : bench drives rx_ack explicitly to pop, skip or coincide with frame ends.
module tb_uart_rx_buffered;

    logic       clk;
    logic       Reset;
    logic       s_ticks;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_done_tick;

    uart_rx_buffered #(
        .Data_bits  (9),
        .Os_ticks   (16),
        .Sync_stages(2)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .s_ticks     (s_ticks),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_done_tick(rx_done_tick)
    );

    int passed = 0;
    int total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversampling strobe: one clk in three, changed on the falling edge.
    int tick_div = 0;
    initial s_ticks = 1'b0;
    always @(negedge clk) begin
        s_ticks  = (tick_div == 2);
        tick_div = (tick_div == 2) ? 0 : tick_div + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor of frame-end pulses.
    int   done_cnt = 0;
    int   dbl_cnt  = 0;
    int   last_done_cyc = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (prev_done) dbl_cnt++;
        end
        prev_done = rx_done_tick;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Wait for n oversampling ticks; returns 1 ns after the last tick edge.
    task automatic tick_wait(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (s_ticks) c++;
        end
        #1;
    endtask

    int frame_start_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
        frame_start_cyc = cyc;
        rx = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_wait(16);
        end
        rx = pbit;
        tick_wait(16);
        rx = stopb;
        if (stopb) begin
            tick_wait(16);
        end else begin
            // Low stop bit long enough to be sampled, then a full idle bit so the
            // trailing low is rejected as a glitch before the next frame.
            tick_wait(10);
            rx = 1'b1;
            tick_wait(16);
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic do_reset();
        tick_wait(1);
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        tick_wait(2);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stopb;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    // Frame-level reference model state.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;

    int d0;
    int lat;
    int ack_target;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};

        Reset  = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data",  {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_flags",    {29'd0, parity_err, frame_err, overrun}, 32'd0);
        check("rst_done",     {31'd0, rx_done_tick}, 32'd0);
        tick_wait(1);
        Reset = 1'b0;
        tick_wait(2);

        // Short low pulse on the line: rejected at mid-start.
        d0 = done_cnt;
        rx = 1'b0;
        tick_wait(4);
        rx = 1'b1;
        tick_wait(16);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_flags",   {28'd0, rx_valid, parity_err, frame_err, overrun}, 32'd0);

        // Directed table; each frame lands in an emptied buffer.
        for (int i = 0; i < 8; i++) begin
            ack_pulse();
            d0 = done_cnt;
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stopb);
            check($sformatf("vec%0d_data", i),  {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_perr", i),  {31'd0, parity_err}, {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d_ferr", i),  {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("vec%0d_done", i),  done_cnt - d0, 1);
        end
        check("table_no_overrun", {31'd0, overrun}, 32'd0);

        // Two frames without a pop: second one dropped.
        do_reset();
        d0 = done_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovr_data",    {24'd0, rx_data}, 32'h11);
        check("ovr_flag",    {31'd0, overrun}, 32'd1);
        check("ovr_valid",   {31'd0, rx_valid}, 32'd1);
        check("ovr_done",    done_cnt - d0, 2);

        // Pop in exactly the frame-end cycle of the second frame.
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1);
        lat = last_done_cyc - frame_start_cyc;
        fork
            send_frame(8'h22, 1'b0, 1'b1);
            begin
                ack_target = cyc + lat - 1;
                while (cyc < ack_target) begin
                    @(posedge clk);
                    #1;
                end
                rx_ack = 1'b1;
                check("coinc_valid_at_ack", {31'd0, rx_valid}, 32'd1);
                @(posedge clk);
                #1;
                rx_ack = 1'b0;
                check("coinc_done_after_ack", {31'd0, rx_done_tick}, 32'd1);
            end
        join
        check("coinc_data",    {24'd0, rx_data}, 32'h22);
        check("coinc_overrun", {31'd0, overrun}, 32'd0);
        check("coinc_valid",   {31'd0, rx_valid}, 32'd1);

        // Reset in the middle of data bit 3, then a clean frame.
        d0 = done_cnt;
        rx = 1'b0;
        tick_wait(16);
        rx = 1'b1; tick_wait(16);
        rx = 1'b0; tick_wait(16);
        rx = 1'b1; tick_wait(16);
        rx = 1'b1; tick_wait(8);
        Reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_data",  {24'd0, rx_data}, 32'h00);
        Reset = 1'b0;
        tick_wait(20);
        check("midrst_no_done", done_cnt - d0, 0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("midrst_f0_data",  {24'd0, rx_data}, 32'hF0);
        check("midrst_f0_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        check("midrst_f0_valid", {31'd0, rx_valid}, 32'd1);
        check("midrst_f0_done",  done_cnt - d0, 1);

        // Randomized frames against the frame-level model.
        do_reset();
        m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic       pb;
            logic       sb;
            d  = 8'($urandom_range(0, 255));
            pb = (^d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 2) != 0) begin
                ack_pulse();
                m_valid = 1'b0;
            end
            d0 = done_cnt;
            send_frame(d, pb, sb);
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = d;
                m_perr  = ((^d) != pb);
                m_ferr  = !sb;
            end else begin
                m_ovr = 1'b1;
            end
            check($sformatf("rnd%0d_data", k),  {24'd0, rx_data}, {24'd0, m_data});
            check($sformatf("rnd%0d_flags", k), {28'd0, rx_valid, parity_err, frame_err, overrun},
                  {28'd0, m_valid, m_perr, m_ferr, m_ovr});
            check($sformatf("rnd%0d_done", k),  done_cnt - d0, 1);
        end

        check("done_single_pulse", dbl_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
